// File: rtl/load_store_unit.sv
// Sequential load/store front end for the multi-cycle core's data memory.
// Build option LSU_MISALIGN_SPLIT_EN: split misaligned accesses into bytes (else fault them).
module load_store_unit #(
   parameter int         ADDR_WIDTH = 32,
   parameter logic [1:0] SIZE_BYTE  = 2'b00,
   parameter logic [1:0] SIZE_HALF  = 2'b01,
   parameter logic [1:0] SIZE_WORD  = 2'b10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_wr,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   input  logic [1:0]            req_size,
   input  logic                  req_sz_ex,
   output logic                  resp_valid,
   output logic [31:0]           resp_rdata,
   output logic                  resp_fault,
   output logic                  mem_wr_en,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [31:0]           mem_in_val,
   output logic [1:0]            mem_size,
   output logic                  mem_sz_ex,
   input  logic [31:0]           mem_out_val
);

   typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP} state_t;

   state_t state;
   logic   aligned;

   always_comb begin
      aligned = (req_size == SIZE_BYTE) ||
                ((req_size == SIZE_HALF) && !req_addr[0]) ||
                ((req_size == SIZE_WORD) && (req_addr[1:0] == 2'b00));
   end

`ifdef LSU_MISALIGN_SPLIT_EN
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [31:0]           wdata_q;
   logic [1:0]            size_q;
   logic                  sz_ex_q;
   logic [23:0]           acc;
   logic [1:0]            idx;
   logic [1:0]            next_idx;
   logic [1:0]            last_idx;

   function automatic logic [31:0] extend_half(input logic [15:0] h, input logic sx);
      return {{16{sx & h[15]}}, h};
   endfunction

   always_comb begin
      next_idx = idx + 2'd1;
      last_idx = (size_q == SIZE_HALF) ? 2'd1 : 2'd3;
   end

   // Request fields and collected load bytes are datapath only, so they carry no reset.
   always_ff @(posedge clk) begin
      if ((state == IDLE) && req_valid) begin
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
         size_q  <= req_size;
         sz_ex_q <= req_sz_ex;
      end
      if (state == SPLIT) begin
         case (idx)
            2'd0:    acc[7:0]   <= mem_out_val[7:0];
            2'd1:    acc[15:8]  <= mem_out_val[7:0];
            2'd2:    acc[23:16] <= mem_out_val[7:0];
            default: ;
         endcase
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         req_ready   <= 1'b1;
         resp_valid  <= 1'b0;
         resp_rdata  <= '0;
         resp_fault  <= 1'b0;
         mem_wr_en   <= 1'b0;
         mem_address <= '0;
         mem_in_val  <= '0;
         mem_size    <= '0;
         mem_sz_ex   <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
         idx         <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  req_ready <= 1'b0;
                  if (req_size == 2'b11) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_fault <= 1'b1;
                  end else if (aligned) begin
                     state       <= ACCESS;
                     mem_wr_en   <= req_wr;
                     mem_address <= req_addr;
                     mem_in_val  <= req_wdata;
                     mem_size    <= req_size;
                     mem_sz_ex   <= req_sz_ex;
                  end else begin
`ifdef LSU_MISALIGN_SPLIT_EN
                     state       <= SPLIT;
                     idx         <= '0;
                     mem_wr_en   <= req_wr;
                     mem_address <= req_addr;
                     mem_in_val  <= {24'h0, req_wdata[7:0]};
                     mem_size    <= SIZE_BYTE;
                     mem_sz_ex   <= 1'b0;
`else
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_fault <= 1'b1;
`endif
                  end
               end
            end
            ACCESS: begin
               // Memory already extended the value; it is returned as-is.
               state       <= RESP;
               resp_valid  <= 1'b1;
               resp_rdata  <= mem_wr_en ? 32'h0 : mem_out_val;
               mem_wr_en   <= 1'b0;
               mem_address <= '0;
               mem_in_val  <= '0;
               mem_size    <= '0;
               mem_sz_ex   <= 1'b0;
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            SPLIT: begin
               if (idx == last_idx) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  if (mem_wr_en)
                     resp_rdata <= 32'h0;
                  else if (size_q == SIZE_HALF)
                     resp_rdata <= extend_half({mem_out_val[7:0], acc[7:0]}, sz_ex_q);
                  else
                     resp_rdata <= {mem_out_val[7:0], acc};
                  mem_wr_en   <= 1'b0;
                  mem_address <= '0;
                  mem_in_val  <= '0;
                  mem_size    <= '0;
                  mem_sz_ex   <= 1'b0;
               end else begin
                  idx         <= next_idx;
                  mem_address <= addr_q + ADDR_WIDTH'(next_idx);
                  mem_in_val  <= {24'h0, wdata_q[{next_idx, 3'b000} +: 8]};
               end
            end
`endif
            RESP: begin
               state      <= IDLE;
               req_ready  <= 1'b1;
               resp_valid <= 1'b0;
               resp_rdata <= '0;
               resp_fault <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-addressed memory model (256 bytes, init mem[i]=i).
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_wr = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [1:0]  req_size = '0;
   logic        req_sz_ex = 1'b0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_fault;
   logic        mem_wr_en;
   logic [31:0] mem_address;
   logic [31:0] mem_in_val;
   logic [1:0]  mem_size;
   logic        mem_sz_ex;
   logic [31:0] mem_out_val;

   int total = 0;
   int bad = 0;

   logic [7:0]  mem [256];
   logic        do_init = 1'b1;
   int          wr_count = 0;
   logic [31:0] wlog_addr [64];
   logic [31:0] wlog_val [64];
   logic [7:0]  rb0, rb1, rb2, rb3;

   load_store_unit dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_sz_ex(req_sz_ex),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
      .mem_wr_en(mem_wr_en), .mem_address(mem_address), .mem_in_val(mem_in_val),
      .mem_size(mem_size), .mem_sz_ex(mem_sz_ex), .mem_out_val(mem_out_val)
   );

   always #5 clk = ~clk;

   // Memory read is combinational and performs the size/sign extension itself.
   always_comb begin
      rb0 = mem[mem_address[7:0]];
      rb1 = mem[mem_address[7:0] + 8'd1];
      rb2 = mem[mem_address[7:0] + 8'd2];
      rb3 = mem[mem_address[7:0] + 8'd3];
      case (mem_size)
         2'b00:   mem_out_val = {{24{mem_sz_ex & rb0[7]}}, rb0};
         2'b01:   mem_out_val = {{16{mem_sz_ex & rb1[7]}}, rb1, rb0};
         default: mem_out_val = {rb3, rb2, rb1, rb0};
      endcase
   end

   always @(posedge clk) begin
      if (do_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
      end else if (mem_wr_en) begin
         mem[mem_address[7:0]] <= mem_in_val[7:0];
         if (mem_size != 2'b00) mem[mem_address[7:0] + 8'd1] <= mem_in_val[15:8];
         if (mem_size == 2'b10) begin
            mem[mem_address[7:0] + 8'd2] <= mem_in_val[23:16];
            mem[mem_address[7:0] + 8'd3] <= mem_in_val[31:24];
         end
         wlog_addr[wr_count[5:0]] <= mem_address;
         wlog_val[wr_count[5:0]]  <= mem_in_val;
         wr_count <= wr_count + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", tag, got, exp);
      end
   endtask

   task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic sx,
                         output logic [31:0] rdata, output logic fault,
                         output int lat, output int nwr, output int base);
      @(negedge clk);
      req_valid = 1'b1;
      req_wr    = wr;
      req_addr  = addr;
      req_wdata = wdata;
      req_size  = size;
      req_sz_ex = sx;
      base      = wr_count;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_wdata = ~wdata;
      req_addr  = addr + 32'h10;
      lat   = -1;
      rdata = 32'h0;
      fault = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (resp_valid) begin
            lat   = k;
            rdata = resp_rdata;
            fault = resp_fault;
            break;
         end
      end
      nwr = wr_count - base;
   endtask

   initial begin
      logic [31:0] rd;
      logic        flt;
      int          lat, nwr, base, seen;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst ready", {31'h0, req_ready}, 32'h1);
      check("rst resp_valid", {31'h0, resp_valid}, 32'h0);
      check("rst wr_en", {31'h0, mem_wr_en}, 32'h0);
      check("rst address", mem_address, 32'h0);
      do_init = 1'b0;
      rst     = 1'b0;

      // Aligned word store then load
      do_req(1'b1, 32'h0, 32'hFF00FF00, 2'b10, 1'b0, rd, flt, lat, nwr, base);
      check("t1 st lat", lat, 2);
      check("t1 st writes", nwr, 1);
      check("t1 st fault", {31'h0, flt}, 32'h0);
      check("t1 st rdata", rd, 32'h0);
      do_req(1'b0, 32'h0, 32'h0, 2'b10, 1'b0, rd, flt, lat, nwr, base);
      check("t1 ld lat", lat, 2);
      check("t1 ld rdata", rd, 32'hFF00FF00);
      check("t1 ld fault", {31'h0, flt}, 32'h0);
      check("t1 ld writes", nwr, 0);

      // Aligned half with sign and zero extension
      do_req(1'b1, 32'h80, 32'h00008001, 2'b01, 1'b0, rd, flt, lat, nwr, base);
      check("t2 st writes", nwr, 1);
      do_req(1'b0, 32'h80, 32'h0, 2'b01, 1'b1, rd, flt, lat, nwr, base);
      check("t2 ld sx rdata", rd, 32'hFFFF8001);
      do_req(1'b0, 32'h80, 32'h0, 2'b01, 1'b0, rd, flt, lat, nwr, base);
      check("t2 ld zx rdata", rd, 32'h00008001);
      do_req(1'b0, 32'h83, 32'h0, 2'b00, 1'b1, rd, flt, lat, nwr, base);
      check("t2 ld byte sx", rd, 32'hFFFFFF83);

`ifdef LSU_MISALIGN_SPLIT_EN
      // Misaligned word store split into four byte writes
      do_req(1'b1, 32'h81, 32'h11223344, 2'b10, 1'b0, rd, flt, lat, nwr, base);
      check("t3 st lat", lat, 5);
      check("t3 st writes", nwr, 4);
      check("t3 st fault", {31'h0, flt}, 32'h0);
      for (int k = 0; k < 4; k++) begin
         check("t3 wr addr", wlog_addr[(base + k) % 64], 32'h81 + 32'(k));
         check("t3 wr val", wlog_val[(base + k) % 64], 32'h44 - 32'h11 * 32'(k));
      end
      do_req(1'b0, 32'h81, 32'h0, 2'b10, 1'b0, rd, flt, lat, nwr, base);
      check("t3 ld word lat", lat, 5);
      check("t3 ld word rdata", rd, 32'h11223344);
      check("t3 ld word writes", nwr, 0);
      do_req(1'b0, 32'h83, 32'h0, 2'b01, 1'b1, rd, flt, lat, nwr, base);
      check("t3 ld half lat", lat, 3);
      check("t3 ld half rdata", rd, 32'h00001122);
      do_req(1'b1, 32'h91, 32'h0000C3B2, 2'b01, 1'b0, rd, flt, lat, nwr, base);
      do_req(1'b0, 32'h91, 32'h0, 2'b01, 1'b1, rd, flt, lat, nwr, base);
      check("t3 ld half neg", rd, 32'hFFFFC3B2);
`else
      // Misaligned word store faults without touching memory
      do_req(1'b1, 32'h81, 32'hCAFEBABE, 2'b10, 1'b0, rd, flt, lat, nwr, base);
      check("t4 st lat", lat, 1);
      check("t4 st fault", {31'h0, flt}, 32'h1);
      check("t4 st rdata", rd, 32'h0);
      check("t4 st writes", nwr, 0);
      do_req(1'b0, 32'h80, 32'h0, 2'b10, 1'b0, rd, flt, lat, nwr, base);
      check("t4 ld rdata", rd, 32'h83828001);
      check("t4 ld fault", {31'h0, flt}, 32'h0);
      do_req(1'b0, 32'h83, 32'h0, 2'b01, 1'b1, rd, flt, lat, nwr, base);
      check("t4 ld half fault", {31'h0, flt}, 32'h1);
`endif

      // Illegal size code with req_valid held high across the response
      @(negedge clk);
      req_valid = 1'b1;
      req_wr    = 1'b1;
      req_addr  = 32'h24;
      req_wdata = 32'hA5A5A5A5;
      req_size  = 2'b11;
      base      = wr_count;
      @(negedge clk);
      check("t5 c1 valid", {31'h0, resp_valid}, 32'h1);
      check("t5 c1 fault", {31'h0, resp_fault}, 32'h1);
      check("t5 c1 rdata", resp_rdata, 32'h0);
      check("t5 c1 ready", {31'h0, req_ready}, 32'h0);
      check("t5 c1 wr_en", {31'h0, mem_wr_en}, 32'h0);
      @(negedge clk);
      check("t5 c2 valid", {31'h0, resp_valid}, 32'h0);
      check("t5 c2 ready", {31'h0, req_ready}, 32'h1);
      @(negedge clk);
      check("t5 c3 valid", {31'h0, resp_valid}, 32'h1);
      req_valid = 1'b0;
      check("t5 writes", wr_count - base, 0);
      @(negedge clk);

`ifdef LSU_MISALIGN_SPLIT_EN
      // Reset during the second byte of a split store
      @(negedge clk);
      req_valid = 1'b1;
      req_wr    = 1'b1;
      req_addr  = 32'h41;
      req_wdata = 32'h55667788;
      req_size  = 2'b10;
      req_sz_ex = 1'b0;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("t6 pre addr", mem_address, 32'h42);
      rst = 1'b1;
      #1;
      check("t6 rst wr_en", {31'h0, mem_wr_en}, 32'h0);
      check("t6 rst addr", mem_address, 32'h0);
      check("t6 rst in_val", mem_in_val, 32'h0);
      check("t6 rst ready", {31'h0, req_ready}, 32'h1);
      @(posedge clk);
      @(negedge clk);
      rst  = 1'b0;
      seen = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (resp_valid) seen++;
      end
      check("t6 no resp", seen, 0);
      do_req(1'b0, 32'h41, 32'h0, 2'b00, 1'b0, rd, flt, lat, nwr, base);
      check("t6 byte41", rd, 32'h88);
      do_req(1'b0, 32'h42, 32'h0, 2'b00, 1'b0, rd, flt, lat, nwr, base);
      check("t6 byte42", rd, 32'h42);
      do_req(1'b0, 32'h43, 32'h0, 2'b00, 1'b0, rd, flt, lat, nwr, base);
      check("t6 byte43", rd, 32'h43);
      do_req(1'b0, 32'h44, 32'h0, 2'b00, 1'b0, rd, flt, lat, nwr, base);
      check("t6 byte44", rd, 32'h44);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
